// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receive-FIFO read/status bundle for uart_rx_fifo
// master: the receiver drives data/status and listens to ack_i/clear_i
// slave : the consumer reads data/status and drives ack_i/clear_i
interface uart_rx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_BITS-1:0] data_o;
  logic                 ready_o;
  logic [CNT_W-1:0]     count_o;
  logic                 parity_error_o;
  logic                 framing_error_o;
  logic                 overrun_o;
  logic                 ack_i;
  logic                 clear_i;

  modport master (
    output data_o, ready_o, count_o, parity_error_o, framing_error_o, overrun_o,
    input  ack_i, clear_i
  );

  modport slave (
    input  data_o, ready_o, count_o, parity_error_o, framing_error_o, overrun_o,
    output ack_i, clear_i
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART frame receiver feeding a small receive FIFO
// clock_i/reset_i      : single clock, synchronous active-high reset
// serial_i             : asynchronous serial line, idles high
// clock_divider_i      : clock cycles per bit (0 and 1 act as 2)
// parity_bit_i/parity_even_i/two_stop_i : frame format, latched at start bit
// fifo_if              : head word, parity tag, count, ready, sticky errors, ack/clear
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 serial_i,
  input  logic [DIV_WIDTH-1:0] clock_divider_i,
  input  logic                 parity_bit_i,
  input  logic                 parity_even_i,
  input  logic                 two_stop_i,
  uart_rx_fifo_if.master       fifo_if
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH} state_t;

  state_t               state;
  logic [1:0]           sync;
  logic                 rx;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] target;
  logic [BIT_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] data_sr;
  logic                 par_tag_q;
  logic                 par_en_q;
  logic                 par_even_q;
  logic                 two_stop_q;
  logic                 tick;
  logic                 push;
  logic                 fe_set;

  logic [DATA_BITS:0]   mem [FIFO_DEPTH];
  logic [DATA_BITS:0]   head;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 ack_q;
  logic                 pop;
  logic                 wr_en;
  logic                 ov_set;
  logic                 fe_q;
  logic                 ov_q;

  assign rx = sync[1];

  // The start bit is sampled at half a bit time, every later sample a full bit later.
  always_comb begin
    target = (state == START) ? (div_q >> 1) : div_q;
    tick   = (cnt == target - DIV_WIDTH'(1));
    push   = tick && rx && ((state == STOP1 && !two_stop_q) || state == STOP2);
    fe_set = tick && !rx && (state == STOP1 || state == STOP2);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync       <= 2'b11;
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      data_sr    <= '0;
      par_tag_q  <= 1'b0;
      div_q      <= DIV_WIDTH'(2);
      par_en_q   <= 1'b0;
      par_even_q <= 1'b0;
      two_stop_q <= 1'b0;
    end else begin
      sync <= {sync[0], serial_i};
      case (state)
        IDLE: begin
          if (!rx) begin
            state      <= START;
            cnt        <= '0;
            div_q      <= (clock_divider_i < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : clock_divider_i;
            par_en_q   <= parity_bit_i;
            par_even_q <= parity_even_i;
            two_stop_q <= two_stop_i;
            par_tag_q  <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx ? IDLE : DATA;
          end else begin
            cnt <= cnt + DIV_WIDTH'(1);
          end
        end
        DATA: begin
          if (tick) begin
            cnt     <= '0;
            data_sr <= {rx, data_sr[DATA_BITS-1:1]};
            bit_idx <= bit_idx + BIT_W'(1);
            if (bit_idx == BIT_W'(DATA_BITS - 1))
              state <= par_en_q ? PARITY : STOP1;
          end else begin
            cnt <= cnt + DIV_WIDTH'(1);
          end
        end
        PARITY: begin
          if (tick) begin
            cnt       <= '0;
            // Odd parity expects the XOR to be 1, so inverting for odd folds both cases.
            par_tag_q <= (^data_sr) ^ rx ^ ~par_even_q;
            state     <= STOP1;
          end else begin
            cnt <= cnt + DIV_WIDTH'(1);
          end
        end
        STOP1: begin
          if (tick) begin
            cnt <= '0;
            if (!rx)            state <= WAIT_HIGH;
            else if (two_stop_q) state <= STOP2;
            else                state <= IDLE;
          end else begin
            cnt <= cnt + DIV_WIDTH'(1);
          end
        end
        STOP2: begin
          if (tick) begin
            cnt   <= '0;
            state <= rx ? IDLE : WAIT_HIGH;
          end else begin
            cnt <= cnt + DIV_WIDTH'(1);
          end
        end
        WAIT_HIGH: begin
          // A break stays here without re-flagging until the line recovers.
          if (rx) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Only the rising edge of ack pops; an edge on an empty FIFO is simply consumed.
  always_comb begin
    pop    = fifo_if.ack_i && !ack_q && (count != '0);
    wr_en  = push && ((count != CNT_W'(FIFO_DEPTH)) || pop);
    ov_set = push && (count == CNT_W'(FIFO_DEPTH)) && !pop;
  end

  always_ff @(posedge clock_i) begin
    if (wr_en) mem[wr_ptr] <= {par_tag_q, data_sr};
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ack_q  <= 1'b1;
      fe_q   <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      ack_q <= fifo_if.ack_i;
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A fresh error in the clearing cycle keeps the flag set.
      fe_q <= (fe_q && !fifo_if.clear_i) || fe_set;
      ov_q <= (ov_q && !fifo_if.clear_i) || ov_set;
    end
  end

  assign head                    = mem[rd_ptr];
  assign fifo_if.ready_o         = (count != '0);
  assign fifo_if.count_o         = count;
  assign fifo_if.data_o          = (count != '0) ? head[DATA_BITS-1:0] : '0;
  assign fifo_if.parity_error_o  = (count != '0) && head[DATA_BITS];
  assign fifo_if.framing_error_o = fe_q;
  assign fifo_if.overrun_o       = ov_q;
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DATA_BITS, default 8, sets the data bits per frame; legal range 5..9.
REQ-002 Parameter FIFO_DEPTH, default 4, sets the receive FIFO entry count; must be a power of 2, at least 2.
REQ-003 Parameter DIV_WIDTH, default 16, sets the width of the clock divider input.
REQ-004 clock_i  in  1  single clock; all logic rising-edge.
REQ-005 reset_i  in  1  synchronous, active-high reset.
REQ-006 serial_i  in  1  asynchronous serial line; idles high.
REQ-007 clock_divider_i  in  DIV_WIDTH  clock_i cycles per bit; values 0 and 1 behave as 2.
REQ-008 parity_bit_i  in  1  when 1, the frame carries a parity bit after the data bits.
REQ-009 parity_even_i  in  1  when 1, parity is even; when 0, parity is odd.
REQ-010 two_stop_i  in  1  when 1, the frame carries two stop bits.
REQ-011 ack_i  in  1  pop request; rising-edge (one-shot) sensitive.
REQ-012 clear_i  in  1  when high, clears the sticky error flags.
REQ-013 data_o  out  DATA_BITS  head-of-FIFO word; 0 when the FIFO is empty.
REQ-014 ready_o  out  1  FIFO is not empty.
REQ-015 count_o  out  clog2(FIFO_DEPTH)+1  number of stored words.
REQ-016 parity_error_o  out  1  parity-error tag of the head entry; 0 when empty.
REQ-017 framing_error_o  out  1  sticky flag: a frame was discarded on a bad stop bit.
REQ-018 overrun_o  out  1  sticky flag: a word was dropped because the FIFO was full.

Function
REQ-019 serial_i shall pass through a 2-flop synchronizer; all line sampling shall use the synchronized value.
REQ-020 Receiver FSM states shall be IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH.
REQ-021 IDLE -> START when the synchronized line is low; the divider, parity_bit_i, parity_even_i and two_stop_i shall be latched at this transition and held for the whole frame.
REQ-022 START: after floor(div/2) cycles, sample the line; if high (glitch) -> IDLE, if low -> DATA.
REQ-023 DATA: sample every div cycles, LSB first, DATA_BITS samples; then -> PARITY if parity is enabled, else -> STOP1.
REQ-024 PARITY: sample after div cycles; the entry's parity-error tag = (XOR of data and parity bit) != (even ? 0 : 1).
REQ-025 STOP1: sample after div cycles; if low -> discard the word, set framing_error_o, go to WAIT_HIGH; if high -> STOP2 when two_stop is set, else push the word and go to IDLE.
REQ-026 STOP2: sample after div cycles; handle a low or high sample as in STOP1, then go to IDLE on success.
REQ-027 WAIT_HIGH: remain until the line is sampled high, then go to IDLE; a break condition shall produce exactly one framing error.
REQ-028 Push timing: the word and its parity tag shall be visible on data_o, ready_o and count_o on the cycle after the final stop-bit sample.
REQ-029 Pop: occurs when ack_i is high and its registered previous value is low and the FIFO is non-empty; holding ack_i high shall pop exactly one entry.
REQ-030 An ack rising edge while the FIFO is empty shall be consumed with no effect; a push in the same cycle shall not be popped.
REQ-031 Push to a full FIFO with no pop in the same cycle: drop the new word, set overrun_o, leave existing contents unchanged.
REQ-032 Push and pop in the same cycle on a full FIFO: both succeed, count_o unchanged, overrun_o not set.
REQ-033 Read/write pointers shall wrap modulo FIFO_DEPTH; count_o shall saturate between 0 and FIFO_DEPTH by construction.
REQ-034 clear_i clears framing_error_o and overrun_o on the next edge; a new error in the same cycle as clear_i wins (the flag stays set).

Reset
REQ-035 reset_i high shall force: FSM to IDLE, synchronizer flops to 1, FIFO pointers and count to 0, ready_o 0, data_o 0, parity_error_o 0, framing_error_o 0, overrun_o 0.
REQ-036 The ack_i history register shall reset to 1, so an ack_i held high across reset does not pop.
REQ-037 Reset asserted mid-frame shall abandon the frame; no partial word shall be pushed.

Verification
REQ-038 DATA_BITS=8, div=2, no parity, 1 stop; send 0x55 then 0xAA -> data_o 0x55, count_o 2; ack pulse -> data_o 0xAA, count_o 1.
REQ-039 ack_i held high while 0xCC arrives after 0xAA was popped -> 0xCC remains, ready_o 1; ack low then high -> ready_o 0.
REQ-040 FIFO_DEPTH=4; send 5 words with no ack -> count_o 4, overrun_o 1, data_o is the first word; clear_i -> overrun_o 0.
REQ-041 Even parity, 0x07 sent with parity bit 0 -> parity_error_o 1 at the head; 0x07 sent with parity bit 1 -> tag 0.
REQ-042 Stop bit forced low, then line held low for 40 bit times -> framing_error_o 1, count_o unchanged, one error only; the next valid frame is received correctly.
REQ-043 DATA_BITS=9, div=7, two stop bits, 0x1A5 sent -> data_o 0x1A5; a 1-cycle low glitch on an idle line -> no push.
